// File: rtl/noc_vc_out_arbiter.sv
// Round-robin virtual-channel arbiter driving one registered NoC output link.
// Define NOC_VC_ARB_PKT_LOCK_EN to hold the link for a whole packet (header..last).
module noc_vc_out_arbiter #(
    parameter int noc_flit_data_width = 32,
    parameter int noc_flit_type_width = 2,
    parameter int vchannels           = 3
) (
    input  logic                                                        clk,
    input  logic                                                        rst_sys_n,
    input  logic [vchannels*(noc_flit_data_width+noc_flit_type_width)-1:0] in_flit,
    input  logic [vchannels-1:0]                                        in_valid,
    output logic [vchannels-1:0]                                        in_ready,
    output logic [noc_flit_data_width+noc_flit_type_width-1:0]          noc_out_flit,
    output logic [vchannels-1:0]                                        noc_out_valid,
    input  logic [vchannels-1:0]                                        noc_out_ready
);

    localparam int noc_flit_width = noc_flit_data_width + noc_flit_type_width;
    localparam int ptr_w = (vchannels > 1) ? $clog2(vchannels) : 1;
    localparam logic [ptr_w-1:0] rr_reset = ptr_w'(vchannels - 1);

    logic [ptr_w-1:0]          rr_ptr;
    logic [ptr_w-1:0]          grant_idx;
    logic                      grant_any;
    logic [vchannels-1:0]      eligible;
    logic [noc_flit_width-1:0] grant_flit;
    logic                      drain;
    logic                      can_load;
    logic                      accept;

`ifdef NOC_VC_ARB_PKT_LOCK_EN
    localparam logic [noc_flit_type_width-1:0] flit_header = noc_flit_type_width'(2'b01);
    localparam logic [noc_flit_type_width-1:0] flit_last   = noc_flit_type_width'(2'b10);

    logic                           lock_active;
    logic [ptr_w-1:0]               lock_owner;
    logic [noc_flit_type_width-1:0] grant_type;

    assign grant_type = grant_flit[noc_flit_width-1 -: noc_flit_type_width];

    always_comb begin
        for (int v = 0; v < vchannels; v++) begin
            eligible[v] = in_valid[v] & noc_out_ready[v] &
                          (!lock_active || (lock_owner == ptr_w'(v)));
        end
    end
`else
    assign eligible = in_valid & noc_out_ready;
`endif

    // The stage can take a new flit when empty, or when its current flit leaves this cycle.
    assign drain    = |(noc_out_valid & noc_out_ready);
    assign can_load = ~(|noc_out_valid) | drain;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < vchannels; i++) begin
            logic [ptr_w-1:0] idx;
            idx = ptr_w'((int'(rr_ptr) + 1 + i) % vchannels);
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign in_ready   = (grant_any && can_load && rst_sys_n) ? (vchannels'(1) << grant_idx) : '0;
    assign accept     = |(in_valid & in_ready);
    assign grant_flit = in_flit[int'(grant_idx)*noc_flit_width +: noc_flit_width];

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            noc_out_valid <= '0;
            noc_out_flit  <= '0;
            rr_ptr        <= rr_reset;
`ifdef NOC_VC_ARB_PKT_LOCK_EN
            lock_active   <= 1'b0;
            lock_owner    <= '0;
`endif
        end else begin
            if (accept) begin
                noc_out_flit  <= grant_flit;
                noc_out_valid <= in_ready;
                rr_ptr        <= grant_idx;
            end else if (drain) begin
                noc_out_valid <= '0;
            end
`ifdef NOC_VC_ARB_PKT_LOCK_EN
            if (accept) begin
                if (grant_type == flit_header) begin
                    lock_active <= 1'b1;
                    lock_owner  <= grant_idx;
                end else if (grant_type == flit_last && lock_active && lock_owner == grant_idx) begin
                    lock_active <= 1'b0;
                end
            end
`endif
        end
    end

endmodule
